// File: rtl/bayer_window_buffer.sv
// bayer_window_buffer: KxK sliding pixel window fed one column per beat,
// with fill tracking, line framing and optional border replication.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid/in_ready  column handshake (ready drops only while flushing)
//   in_sol/in_eol      first/last column of a line
//   in_col             new column, row r at [r*DATA_W +: DATA_W]
//   win                window, pixel (r,c) at [(r*WIN+c)*DATA_W +: DATA_W]
//   out_valid          win holds a complete window
//   out_sol/out_eol    first/last valid window of a line
module bayer_window_buffer #(
    parameter int DATA_W   = 10,
    parameter int WIN      = 3,
    parameter int PAD_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sol,
    input  logic                       in_eol,
    input  logic [WIN*DATA_W-1:0]      in_col,
    output logic [WIN*WIN*DATA_W-1:0]  win,
    output logic                       out_valid,
    output logic                       out_sol,
    output logic                       out_eol
);

    localparam int HALF = WIN / 2;
    localparam int FW   = $clog2(WIN + 1);
    localparam int FLW  = (HALF < 1) ? 1 : $clog2(HALF + 1);
    localparam int CW   = WIN * DATA_W;
    localparam int WW   = WIN * WIN * DATA_W;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [FLW-1:0]  flush_q, flush_d;
    logic            sol_pend_q, sol_pend_d;
    logic [WW-1:0]   win_q, win_d;
    logic            valid_q, valid_d;
    logic            sol_q, sol_d;
    logic            eol_q, eol_d;

    logic            accept;
    logic            shift_en;
    logic            load_en;
    logic            pend;
    logic [CW-1:0]   new_col;
    logic [CW-1:0]   last_col;
    logic [FW-1:0]   fill_inc;
    logic [FW-1:0]   fill_n;

    // Ready is a decode of the registered state, so it is registered too.
    // Without padding the FSM never leaves RUN.
    assign in_ready  = (state_q == RUN);
    assign accept    = in_valid && in_ready;
    assign win       = win_q;
    assign out_valid = valid_q;
    assign out_sol   = sol_q;
    assign out_eol   = eol_q;

    assign fill_inc = (fill_q == FW'(WIN)) ? fill_q : fill_q + 1'b1;

    // Newest column of the current window, replicated during flush.
    always_comb begin
        last_col = '0;
        for (int r = 0; r < WIN; r++) begin
            last_col[r*DATA_W +: DATA_W] =
                win_q[(r*WIN + WIN - 1)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        flush_d    = flush_q;
        sol_pend_d = sol_pend_q;
        valid_d    = 1'b0;
        sol_d      = 1'b0;
        eol_d      = 1'b0;
        shift_en   = 1'b0;
        load_en    = 1'b0;
        pend       = 1'b0;
        new_col    = '0;
        fill_n     = fill_q;

        unique case (state_q)
            RUN: begin
                if (accept) begin
                    new_col = in_col;
                    if (in_sol && (PAD_MODE == 1)) begin
                        load_en = 1'b1;
                        fill_n  = FW'(HALF + 1);
                    end else if (in_sol) begin
                        shift_en = 1'b1;
                        fill_n   = FW'(1);
                    end else begin
                        shift_en = 1'b1;
                        fill_n   = fill_inc;
                    end
                    pend       = sol_pend_q || in_sol;
                    valid_d    = (fill_n == FW'(WIN));
                    sol_d      = valid_d && pend;
                    sol_pend_d = pend && !valid_d;
                    fill_d     = fill_n;
                    if (in_eol) begin
                        if (PAD_MODE == 1) begin
                            state_d = FLUSH;
                            flush_d = FLW'(HALF);
                        end else begin
                            eol_d  = valid_d;
                            fill_d = '0;
                        end
                    end
                end
            end
            FLUSH: begin
                new_col    = last_col;
                shift_en   = 1'b1;
                fill_n     = fill_inc;
                valid_d    = (fill_n == FW'(WIN));
                sol_d      = valid_d && sol_pend_q;
                sol_pend_d = sol_pend_q && !valid_d;
                fill_d     = fill_n;
                flush_d    = flush_q - 1'b1;
                if (flush_q == FLW'(1)) begin
                    eol_d   = valid_d;
                    fill_d  = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Column shift / border load; rows are never mixed.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                if (load_en) begin
                    win_d[(r*WIN + c)*DATA_W +: DATA_W] =
                        new_col[r*DATA_W +: DATA_W];
                end else if (shift_en) begin
                    if (c < WIN - 1) begin
                        win_d[(r*WIN + c)*DATA_W +: DATA_W] =
                            win_q[(r*WIN + c + 1)*DATA_W +: DATA_W];
                    end else begin
                        win_d[(r*WIN + c)*DATA_W +: DATA_W] =
                            new_col[r*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fill_q     <= '0;
            flush_q    <= '0;
            sol_pend_q <= 1'b0;
            win_q      <= '0;
            valid_q    <= 1'b0;
            sol_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            flush_q    <= flush_d;
            sol_pend_q <= sol_pend_d;
            win_q      <= win_d;
            valid_q    <= valid_d;
            sol_q      <= sol_d;
            eol_q      <= eol_d;
        end
    end

endmodule
